// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: encodings shared between the control unit and the memory access unit
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ctrl_e;

  typedef enum logic [1:0] {
    P_GSP = 2'd0,
    P_RP  = 2'd1,
    P_CP  = 2'd2,
    P_STP = 2'd3
  } p_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_WR       = 2'd3
  } state_e;

  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/mem_ptr_mux.sv
// mem_ptr_mux: combinational 4:1 select of the pointer register that addresses the RAM
module mem_ptr_mux
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [1:0]        i_p_ctrl,
  input  logic [ADDR_W-1:0] i_gsp,
  input  logic [ADDR_W-1:0] i_rp,
  input  logic [ADDR_W-1:0] i_cp,
  input  logic [ADDR_W-1:0] i_stp,
  output logic [ADDR_W-1:0] o_sel_addr
);

  assign o_sel_addr = (i_p_ctrl == P_GSP) ? i_gsp :
                      (i_p_ctrl == P_RP)  ? i_rp  :
                      (i_p_ctrl == P_CP)  ? i_cp  : i_stp;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: responder to the control unit's memory requests; drives the synchronous RAM
// and returns read data on a held mem_out register. Optional bound check: MEM_BOUND_CHECK_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MEM_DEPTH = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_mem_ctrl,
  input  logic [1:0]        i_p_ctrl,
  input  logic [ADDR_W-1:0] i_gsp,
  input  logic [ADDR_W-1:0] i_rp,
  input  logic [ADDR_W-1:0] i_cp,
  input  logic [ADDR_W-1:0] i_stp,
  input  logic [DATA_W-1:0] i_bus_in,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_re,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [DATA_W-1:0] o_mem_out,
  output logic              o_mem_valid,
  output logic              o_busy,
  output logic              o_ovr,
  output logic              o_addr_err
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || MEM_DEPTH < 1) begin : g_bad_param
    $error("mem_access_unit: RD_LAT must be 1..3 and MEM_DEPTH positive");
  end

  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_rd;
  logic              w_wr;
  logic              w_rd_done;
  logic              w_done;
  logic              w_accept;
  logic              w_oob;

  state_e            r_state;
  logic [1:0]        r_cnt;
  logic              r_rd_oob;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_re;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_mem_out;
  logic              r_mem_valid;
  logic              r_busy;
  logic              r_ovr;
  logic              r_addr_err;

  mem_ptr_mux #(.ADDR_W(ADDR_W)) u_ptr_mux (
    .i_p_ctrl   (i_p_ctrl),
    .i_gsp      (i_gsp),
    .i_rp       (i_rp),
    .i_cp       (i_cp),
    .i_stp      (i_stp),
    .o_sel_addr (w_sel_addr)
  );

  assign w_rd      = i_mem_ctrl == MEM_READ;
  assign w_wr      = i_mem_ctrl == MEM_WRITE;
  assign w_rd_done = (r_state == ST_RD_WAIT) && (r_cnt == 2'd0);
  assign w_done    = w_rd_done || (r_state == ST_WR);
  // A request landing on the completion edge is taken, so accesses run back to back
  assign w_accept  = (r_state == ST_IDLE) || w_done;

`ifdef MEM_BOUND_CHECK_EN
  assign w_oob = {1'b0, w_sel_addr} >= (ADDR_W+1)'(MEM_DEPTH);
`else
  assign w_oob = 1'b0;
`endif

  // Access sequencer: accepts requests, strobes the RAM and captures read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_rd_oob    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_mem_out   <= '0;
      r_mem_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ovr       <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_mem_valid <= 1'b0;
      if (r_state == ST_RD_ISSUE) r_state <= ST_RD_WAIT;
      if (r_state == ST_RD_WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (w_rd_done) begin
        r_mem_out   <= r_rd_oob ? '0 : i_ram_rdata;
        r_mem_valid <= 1'b1;
      end
      if (w_accept) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        if (w_rd || w_wr) begin
          r_ram_addr <= w_sel_addr;
          r_busy     <= 1'b1;
          r_rd_oob   <= w_oob;
          if (w_oob) r_addr_err <= 1'b1;
          if (w_rd) begin
            r_ram_re <= !w_oob;
            r_cnt    <= 2'(RD_LAT - 1);
            r_state  <= ST_RD_ISSUE;
          end else begin
            r_ram_wdata <= i_bus_in;
            r_ram_we    <= !w_oob;
            r_state     <= ST_WR;
          end
        end
      end else if (w_rd || w_wr) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign o_ram_addr  = r_ram_addr;
  assign o_ram_re    = r_ram_re;
  assign o_ram_we    = r_ram_we;
  assign o_ram_wdata = r_ram_wdata;
  assign o_mem_out   = r_mem_out;
  assign o_mem_valid = r_mem_valid;
  assign o_busy      = r_busy;
  assign o_ovr       = r_ovr;
  assign o_addr_err  = r_addr_err;

endmodule
